// File: rtl/reel_controller.sv
// Three-reel slot machine controller: credit handling, tick-timed reel spin, staged stops, win evaluation and payout.
// Optional automatic stop when built with REEL_AUTO_STOP_EN defined.
module reel_controller #(
  parameter int         TICK_DIV        = 2_500_000,
  parameter logic [7:0] INIT_CREDIT     = 8'd10,
  parameter int         AUTO_STOP_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic [3:0] rand_num,
  output logic       rand_en,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [7:0] credit,
  output logic [1:0] win,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SPIN3  = 3'd1;
  localparam logic [2:0] SPIN2  = 3'd2;
  localparam logic [2:0] SPIN1  = 3'd3;
  localparam logic [2:0] EVAL   = 3'd4;
  localparam logic [2:0] PAYOUT = 3'd5;

  localparam int            TW       = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  generate
    if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("reel_controller: TICK_DIV must be 2 or more");
    end
    if (AUTO_STOP_TICKS < 1) begin : g_bad_auto_stop
      $error("reel_controller: AUTO_STOP_TICKS must be 1 or more");
    end
  endgenerate

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          stop_pend_q, stop_pend_d;
  logic [3:0]    reel0_q, reel0_d;
  logic [3:0]    reel1_q, reel1_d;
  logic [3:0]    reel2_q, reel2_d;
  logic [7:0]    credit_q, credit_d;
  logic [1:0]    win_q, win_d;

  logic       spinning;
  logic       tick;
  logic       freeze_req;
  logic       freeze;
  logic [7:0] payout_amt;
  logic [8:0] credit_sum;

  assign spinning = (state_q == SPIN3) || (state_q == SPIN2) || (state_q == SPIN1);
  assign tick     = spinning && (tick_cnt_q == TICK_MAX);
  assign freeze   = tick && freeze_req;

`ifdef REEL_AUTO_STOP_EN
  localparam int AW = $clog2(AUTO_STOP_TICKS + 1);

  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          auto_hit;

  // The tick that brings the per-stage count to AUTO_STOP_TICKS is itself the freeze tick.
  assign auto_hit   = (auto_cnt_q == AW'(AUTO_STOP_TICKS - 1));
  assign freeze_req = stop_pend_q || auto_hit;

  always_comb begin
    auto_cnt_d = auto_cnt_q;
    if (!spinning) begin
      auto_cnt_d = '0;
    end else if (freeze) begin
      auto_cnt_d = '0;
    end else if (tick) begin
      auto_cnt_d = auto_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end
`else
  assign freeze_req = stop_pend_q;
`endif

  always_comb begin
    payout_amt = 8'd0;
    if (win_q == 2'b10) begin
      payout_amt = 8'd20;
    end else if (win_q == 2'b01) begin
      payout_amt = 8'd2;
    end
    credit_sum = {1'b0, credit_q} + {1'b0, payout_amt};
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = '0;
    stop_pend_d = stop_pend_q;
    reel0_d     = reel0_q;
    reel1_d     = reel1_q;
    reel2_d     = reel2_q;
    credit_d    = credit_q;
    win_d       = win_q;

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start_btn && (credit_q != 8'd0)) begin
          credit_d = credit_q - 8'd1;
          win_d    = 2'b00;
          state_d  = SPIN3;
        end
      end
      SPIN3, SPIN2, SPIN1: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        if (stop_btn) begin
          stop_pend_d = 1'b1;
        end
        if (tick) begin
          // Leftmost still-spinning reel holds its value on the freeze tick.
          if ((state_q == SPIN3) && !freeze_req) begin
            reel0_d = rand_num;
          end
          if ((state_q == SPIN3) || ((state_q == SPIN2) && !freeze_req)) begin
            reel1_d = rand_num + 4'd5;
          end
          if ((state_q != SPIN1) || !freeze_req) begin
            reel2_d = rand_num + 4'd11;
          end
          if (freeze_req) begin
            stop_pend_d = 1'b0;
            case (state_q)
              SPIN3:   state_d = SPIN2;
              SPIN2:   state_d = SPIN1;
              default: state_d = EVAL;
            endcase
          end
        end
      end
      EVAL: begin
        if ((reel0_q == reel1_q) && (reel1_q == reel2_q)) begin
          win_d = 2'b10;
        end else if ((reel0_q == reel1_q) || (reel1_q == reel2_q) || (reel0_q == reel2_q)) begin
          win_d = 2'b01;
        end else begin
          win_d = 2'b00;
        end
        state_d = PAYOUT;
      end
      PAYOUT: begin
        credit_d = credit_sum[8] ? 8'd255 : credit_sum[7:0];
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
      reel0_q     <= 4'd0;
      reel1_q     <= 4'd0;
      reel2_q     <= 4'd0;
      credit_q    <= INIT_CREDIT;
      win_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      stop_pend_q <= stop_pend_d;
      reel0_q     <= reel0_d;
      reel1_q     <= reel1_d;
      reel2_q     <= reel2_d;
      credit_q    <= credit_d;
      win_q       <= win_d;
    end
  end

  assign rand_en = spinning;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == PAYOUT);
  assign reel0   = reel0_q;
  assign reel1   = reel1_q;
  assign reel2   = reel2_q;
  assign credit  = credit_q;
  assign win     = win_q;

endmodule

// File: tb/tb_reel_controller.sv
// Directed bench for reel_controller with TICK_DIV=4: credit 10, credit 0 and credit 250 instances share stimulus.
module tb_reel_controller;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       stop_btn;
  logic       start_auto;
  logic [3:0] rand_num;

  logic       m_rand_en, m_busy, m_done;
  logic [3:0] m_reel0, m_reel1, m_reel2;
  logic [7:0] m_credit;
  logic [1:0] m_win;

  logic       z_rand_en, z_busy, z_done;
  logic [3:0] z_reel0, z_reel1, z_reel2;
  logic [7:0] z_credit;
  logic [1:0] z_win;

  logic       s_rand_en, s_busy, s_done;
  logic [3:0] s_reel0, s_reel1, s_reel2;
  logic [7:0] s_credit;
  logic [1:0] s_win;

  logic       a_rand_en, a_busy, a_done;
  logic [3:0] a_reel0, a_reel1, a_reel2;
  logic [7:0] a_credit;
  logic [1:0] a_win;

  int checks;
  int failures;
  int done_cnt;

  reel_controller #(.TICK_DIV(4), .INIT_CREDIT(8'd10), .AUTO_STOP_TICKS(40)) u_main (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn), .rand_num(rand_num),
    .rand_en(m_rand_en), .reel0(m_reel0), .reel1(m_reel1), .reel2(m_reel2),
    .credit(m_credit), .win(m_win), .busy(m_busy), .done(m_done));

  reel_controller #(.TICK_DIV(4), .INIT_CREDIT(8'd0), .AUTO_STOP_TICKS(40)) u_zero (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn), .rand_num(rand_num),
    .rand_en(z_rand_en), .reel0(z_reel0), .reel1(z_reel1), .reel2(z_reel2),
    .credit(z_credit), .win(z_win), .busy(z_busy), .done(z_done));

  reel_controller #(.TICK_DIV(4), .INIT_CREDIT(8'd250), .AUTO_STOP_TICKS(40)) u_sat (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn), .rand_num(rand_num),
    .rand_en(s_rand_en), .reel0(s_reel0), .reel1(s_reel1), .reel2(s_reel2),
    .credit(s_credit), .win(s_win), .busy(s_busy), .done(s_done));

  reel_controller #(.TICK_DIV(4), .INIT_CREDIT(8'd10), .AUTO_STOP_TICKS(3)) u_auto (
    .clk(clk), .rst(rst), .start_btn(start_auto), .stop_btn(1'b0), .rand_num(rand_num),
    .rand_en(a_rand_en), .reel0(a_reel0), .reel1(a_reel1), .reel2(a_reel2),
    .credit(a_credit), .win(a_win), .busy(a_busy), .done(a_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_done === 1'b1) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_spin(input logic with_stop);
    start_btn = 1'b1;
    stop_btn  = with_stop;
    cyc(1);
    start_btn = 1'b0;
    stop_btn  = 1'b0;
  endtask

  // One reel stage: a normal tick at rand r, a stop pulse, then the freeze tick.
  task automatic stage(input logic [3:0] r, input logic also_start);
    rand_num = r;
    cyc(4);
    stop_btn  = 1'b1;
    start_btn = also_start;
    cyc(1);
    stop_btn  = 1'b0;
    start_btn = 1'b0;
    cyc(3);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    checks++; if (m_credit !== 8'd10) begin failures++; $display("FAIL rst_credit got %0d exp 10", m_credit); end
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h000) begin failures++; $display("FAIL rst_reels got %h exp 000", {m_reel0, m_reel1, m_reel2}); end
    checks++; if ({m_busy, m_done, m_rand_en, m_win} !== 5'b0) begin failures++; $display("FAIL rst_flags got %b exp 00000", {m_busy, m_done, m_rand_en, m_win}); end
    checks++; if (s_credit !== 8'd250) begin failures++; $display("FAIL rst_sat_credit got %0d exp 250", s_credit); end
    rst = 1'b0;
    cyc(1);
    checks++; if (m_credit !== 8'd10) begin failures++; $display("FAIL rel_credit got %0d exp 10", m_credit); end
    checks++; if ({m_busy, m_rand_en} !== 2'b00) begin failures++; $display("FAIL rel_busy_rand_en got %b exp 00", {m_busy, m_rand_en}); end
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h000) begin failures++; $display("FAIL rel_reels got %h exp 000", {m_reel0, m_reel1, m_reel2}); end
  endtask

  task automatic test_triple;
    start_spin(1'b0);
    checks++; if ({m_busy, m_rand_en} !== 2'b11) begin failures++; $display("FAIL start_busy_rand_en got %b exp 11", {m_busy, m_rand_en}); end
    checks++; if (m_credit !== 8'd9) begin failures++; $display("FAIL start_credit got %0d exp 9", m_credit); end
    checks++; if ({z_busy, z_rand_en} !== 2'b00) begin failures++; $display("FAIL zero_busy_rand_en got %b exp 00", {z_busy, z_rand_en}); end
    checks++; if (z_credit !== 8'd0) begin failures++; $display("FAIL zero_credit got %0d exp 0", z_credit); end
    checks++; if (s_credit !== 8'd249) begin failures++; $display("FAIL sat_start_credit got %0d exp 249", s_credit); end
    stage(4'd4, 1'b0);
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h49F) begin failures++; $display("FAIL stage1_reels got %h exp 49f", {m_reel0, m_reel1, m_reel2}); end
    stage(4'd15, 1'b0);
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h44A) begin failures++; $display("FAIL stage2_reels got %h exp 44a", {m_reel0, m_reel1, m_reel2}); end
    stage(4'd9, 1'b0);
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h444) begin failures++; $display("FAIL triple_reels got %h exp 444", {m_reel0, m_reel1, m_reel2}); end
    checks++; if ({m_busy, m_done, m_rand_en} !== 3'b100) begin failures++; $display("FAIL eval_flags got %b exp 100", {m_busy, m_done, m_rand_en}); end
    cyc(1);
    checks++; if ({m_done, m_win} !== 3'b110) begin failures++; $display("FAIL payout_done_win got %b exp 110", {m_done, m_win}); end
    cyc(1);
    checks++; if ({m_busy, m_done} !== 2'b00) begin failures++; $display("FAIL after_payout_flags got %b exp 00", {m_busy, m_done}); end
    checks++; if (m_credit !== 8'd29) begin failures++; $display("FAIL triple_credit got %0d exp 29", m_credit); end
    checks++; if (s_credit !== 8'd255) begin failures++; $display("FAIL sat_triple_credit got %0d exp 255", s_credit); end
    checks++; if (z_credit !== 8'd0 || z_busy !== 1'b0) begin failures++; $display("FAIL zero_idle got credit %0d busy %b exp 0 0", z_credit, z_busy); end
  endtask

  task automatic test_pair;
    start_spin(1'b0);
    checks++; if (m_credit !== 8'd28) begin failures++; $display("FAIL pair_start_credit got %0d exp 28", m_credit); end
    stage(4'd4, 1'b0);
    stage(4'd15, 1'b0);
    stage(4'd0, 1'b0);
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h44B) begin failures++; $display("FAIL pair_reels got %h exp 44b", {m_reel0, m_reel1, m_reel2}); end
    cyc(1);
    checks++; if ({m_done, m_win} !== 3'b101) begin failures++; $display("FAIL pair_done_win got %b exp 101", {m_done, m_win}); end
    cyc(1);
    checks++; if (m_credit !== 8'd30) begin failures++; $display("FAIL pair_credit got %0d exp 30", m_credit); end
    checks++; if (s_credit !== 8'd255) begin failures++; $display("FAIL sat_pair_credit got %0d exp 255", s_credit); end
  endtask

  task automatic test_none_and_ignores;
    start_spin(1'b1);
    stage(4'd7, 1'b0);
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h7C2) begin failures++; $display("FAIL start_stop_same_cycle_reels got %h exp 7c2", {m_reel0, m_reel1, m_reel2}); end
    stage(4'd0, 1'b1);
    stage(4'd0, 1'b0);
    cyc(2);
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h75B) begin failures++; $display("FAIL none_reels got %h exp 75b", {m_reel0, m_reel1, m_reel2}); end
    checks++; if (m_win !== 2'b00) begin failures++; $display("FAIL none_win got %b exp 00", m_win); end
    checks++; if (m_credit !== 8'd29) begin failures++; $display("FAIL none_credit got %0d exp 29", m_credit); end
    checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL none_busy got %b exp 0", m_busy); end
  endtask

  task automatic test_reset_mid_spin;
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
    start_spin(1'b0);
    stage(4'd3, 1'b0);
    checks++; if (m_reel0 !== 4'd3) begin failures++; $display("FAIL idle_stop_ignored_reel0 got %0d exp 3", m_reel0); end
    checks++; if (m_credit !== 8'd28) begin failures++; $display("FAIL spin4_credit got %0d exp 28", m_credit); end
    cyc(2);
    rst = 1'b1;
    #1;
    checks++; if ({m_reel0, m_reel1, m_reel2} !== 12'h000) begin failures++; $display("FAIL midrst_reels got %h exp 000", {m_reel0, m_reel1, m_reel2}); end
    checks++; if (m_credit !== 8'd10) begin failures++; $display("FAIL midrst_credit got %0d exp 10", m_credit); end
    checks++; if ({m_busy, m_rand_en, m_done, m_win} !== 5'b0) begin failures++; $display("FAIL midrst_flags got %b exp 00000", {m_busy, m_rand_en, m_done, m_win}); end
    checks++; if (s_credit !== 8'd250) begin failures++; $display("FAIL midrst_sat_credit got %0d exp 250", s_credit); end
    cyc(1);
    rst = 1'b0;
    cyc(2);
    checks++; if ({m_busy, m_credit} !== {1'b0, 8'd10}) begin failures++; $display("FAIL postrst got busy %b credit %0d exp 0 10", m_busy, m_credit); end
    checks++; if (done_cnt !== 3) begin failures++; $display("FAIL done_pulses got %0d exp 3", done_cnt); end
  endtask

`ifdef REEL_AUTO_STOP_EN
  task automatic test_auto_stop;
    start_auto = 1'b1;
    cyc(1);
    start_auto = 1'b0;
    cyc(36);
    checks++; if ({a_busy, a_done, a_rand_en} !== 3'b100) begin failures++; $display("FAIL auto_eval got %b exp 100", {a_busy, a_done, a_rand_en}); end
    cyc(1);
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL auto_done got %b exp 1", a_done); end
    cyc(1);
    checks++; if ({a_busy, a_done} !== 2'b00) begin failures++; $display("FAIL auto_idle got %b exp 00", {a_busy, a_done}); end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    done_cnt   = 0;
    rst        = 1'b1;
    start_btn  = 1'b0;
    stop_btn   = 1'b0;
    start_auto = 1'b0;
    rand_num   = 4'd0;
    test_reset();
    test_triple();
    test_pair();
    test_none_and_ignores();
    test_reset_mid_spin();
`ifdef REEL_AUTO_STOP_EN
    test_auto_stop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reel_controller.md
REEL_CONTROLLER -- requirements
Module: reel_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2_500_000: clock cycles per reel tick; legal range is 2 and above.
REQ-002 SHALL have parameter INIT_CREDIT, default 8'd10: credit value loaded at reset.
REQ-003 SHALL have parameter AUTO_STOP_TICKS, default 40: ticks without a stop before an automatic stop (used only under REQ-024).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start_btn  in  1  single-cycle pulse requesting a spin (debounced upstream).
REQ-007 stop_btn  in  1  single-cycle pulse requesting the next reel stop.
REQ-008 rand_num  in  4  value from the random number generator.
REQ-009 rand_en  out  1  enable to the random number generator; 1 in every SPIN state, otherwise 0.
REQ-010 reel0, reel1, reel2  out  4 each  displayed reel symbols.
REQ-011 credit  out  8  current credit count.
REQ-012 win  out  2  result of the last spin: 00 none, 01 pair, 10 triple.
REQ-013 busy  out  1  1 in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse in PAYOUT.

Function
REQ-015 States SHALL be IDLE, SPIN3, SPIN2, SPIN1, EVAL and PAYOUT, held in a registered state machine.
REQ-016 In IDLE, when start_btn=1 and credit!=0: credit-=1, win<=00, tick counter<=0, go to SPIN3; when start_btn=1 and credit==0 the pulse SHALL be ignored.
REQ-017 The tick counter SHALL count 0..TICK_DIV-1 in SPIN states only; tick is 1 when the counter equals TICK_DIV-1, after which the counter wraps to 0.
REQ-018 On each tick, every spinning reel SHALL update: reel0<=rand_num, reel1<=rand_num+5, reel2<=rand_num+11, all modulo 16 (4-bit wrap).
REQ-019 stop_btn in any SPIN state SHALL set stop_pend; stop_btn while stop_pend=1, and stop_btn outside SPIN states, SHALL be ignored.
REQ-020 On a tick with stop_pend=1, the leftmost spinning reel SHALL NOT update on that tick (it freezes at its prior value), the other spinning reels update, stop_pend clears, and state advances SPIN3->SPIN2->SPIN1->EVAL.
REQ-021 EVAL (1 cycle): if all three reels are equal, win<=10; else if any two reels are equal, win<=01; else win<=00.
REQ-022 PAYOUT (1 cycle): credit += 20 for a triple or 2 for a pair, saturating at 255; done=1; next state is IDLE.
REQ-023 start_btn outside IDLE SHALL be ignored; start_btn and stop_btn in the same IDLE cycle: start is taken and stop is ignored.

Configuration
REQ-024 With macro REEL_AUTO_STOP_EN defined, a tick counter SHALL count ticks since entering the current SPIN state; when it reaches AUTO_STOP_TICKS with stop_pend=0, stop_pend SHALL be set. With the macro undefined, reels stop only via stop_btn and the logic is absent.

Reset
REQ-025 While rst=1, the block SHALL hold: state=IDLE, reels=0, credit=INIT_CREDIT, win=00, busy=0, done=0, rand_en=0, all counters=0, stop_pend=0.
REQ-026 Reset asserted mid-spin SHALL abort the spin with no payout; credit returns to INIT_CREDIT.

Verification (use TICK_DIV=4)
REQ-027 Reset release -> credit=10, reels=0/0/0, busy=0, rand_en=0.
REQ-028 start pulse -> next cycle busy=1, rand_en=1, credit=9. Stops with rand_num=4, then 15, then 9 at the freeze ticks -> reels 4/4/4, win=10, done pulse, credit=29, busy=0 the cycle after PAYOUT.
REQ-029 INIT_CREDIT=0, start pulse -> busy stays 0, credit stays 0, rand_en stays 0.
REQ-030 INIT_CREDIT=250, triple -> credit 249 then saturates at 255 (not 13).
REQ-031 rst asserted in SPIN2 -> same cycle state=IDLE, reels=0, credit=INIT_CREDIT, done never pulses.
REQ-032 REEL_AUTO_STOP_EN defined, AUTO_STOP_TICKS=3, no stop_btn -> EVAL entered after 9 ticks, done pulses, busy returns to 0.
